// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem read per instruction and
// holds the fetched word in a registered instruction register. Optional
// misaligned-redirect fault logic is enabled with `define FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc_plus4,
  output logic        fetch_fault,
  output logic [31:0] fault_pc
);

  typedef enum logic [1:0] {REQ, WAIT, OUT, FAULT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        drop;
  logic        req_valid_q;
  logic        inst_valid_q;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic [31:0] redirect_target;

  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_ALIGN_CHECK_EN
  logic        fault_q;
  logic [31:0] fault_pc_q;
  logic        bad_redirect;

  assign bad_redirect = redirect_valid && (redirect_pc[1:0] != 2'b00) && (state != FAULT);
  assign fetch_fault  = fault_q;
  assign fault_pc     = fault_pc_q;
`else
  assign fetch_fault  = 1'b0;
  assign fault_pc     = 32'h0000_0000;
`endif

  // A redirect takes priority over every handshake seen in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= REQ;
      pc           <= RESET_PC;
      drop         <= 1'b0;
      req_valid_q  <= 1'b1;
      inst_valid_q <= 1'b0;
      inst_q       <= NOP_INSN;
      inst_pc_q    <= RESET_PC;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q      <= 1'b0;
      fault_pc_q   <= 32'h0000_0000;
`endif
    end else begin
`ifdef FETCH_ALIGN_CHECK_EN
      if (bad_redirect) begin
        state        <= FAULT;
        drop         <= 1'b0;
        req_valid_q  <= 1'b0;
        inst_valid_q <= 1'b0;
        fault_q      <= 1'b1;
        fault_pc_q   <= redirect_pc;
      end else
`endif
      begin
        case (state)
          REQ: begin
            if (redirect_valid) pc <= redirect_target;
            if (imem_req_ready) begin
              state       <= WAIT;
              req_valid_q <= 1'b0;
              drop        <= redirect_valid;
            end
          end
          WAIT: begin
            if (imem_rsp_valid) begin
              if (redirect_valid || drop) begin
                state       <= REQ;
                req_valid_q <= 1'b1;
                drop        <= 1'b0;
                if (redirect_valid) pc <= redirect_target;
              end else begin
                state        <= OUT;
                inst_valid_q <= 1'b1;
                inst_q       <= imem_rsp_data;
                inst_pc_q    <= pc;
                pc           <= pc + 32'd4;
              end
            end else if (redirect_valid) begin
              pc   <= redirect_target;
              drop <= 1'b1;
            end
          end
          OUT: begin
            if (redirect_valid) begin
              state        <= REQ;
              req_valid_q  <= 1'b1;
              inst_valid_q <= 1'b0;
              inst_q       <= NOP_INSN;
              pc           <= redirect_target;
            end else if (inst_ready) begin
              state        <= REQ;
              req_valid_q  <= 1'b1;
              inst_valid_q <= 1'b0;
            end
          end
          FAULT: begin
            req_valid_q  <= 1'b0;
            inst_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_addr      = pc;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign inst_pc_plus4  = inst_pc_q + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural memory and fetch model push
// expected instructions when memory responds and pop them when decode consumes.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        resetn;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;
  logic        fetch_fault;
  logic [31:0] fault_pc;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSN(NOP)) dut (
    .clk(clk), .resetn(resetn),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .inst_pc_plus4(inst_pc_plus4),
    .fetch_fault(fetch_fault), .fault_pc(fault_pc)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_pc, m_fault_pc, out_addr, redir_target;
  bit m_reqv, m_wait, m_instv, m_stale, m_fault, outstanding, expect_nop, redir_armed, knob_rand;
  int out_cnt, knob_lat, knob_hold, knob_redir_pct, hold_cnt, stall_cnt, redir_when, redir_skip;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0050_0093 : ((a ^ 32'h5A5A_0000) + 32'h0000_0003);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic armRedirect(input int when, input int skip, input logic [31:0] target);
    redir_armed  = 1'b1;
    redir_when   = when;
    redir_skip   = skip;
    redir_target = target;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic doReset();
    resetn         = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b0;
    #2;
    checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("rst_addr", imem_addr, RESET_PC);
    checkOutput("rst_inst_valid", 32'(inst_valid), 32'd0);
    checkOutput("rst_inst", inst, NOP);
    checkOutput("rst_inst_pc", inst_pc, RESET_PC);
    checkOutput("rst_inst_pc_plus4", inst_pc_plus4, RESET_PC + 32'd4);
    checkOutput("rst_fetch_fault", 32'(fetch_fault), 32'd0);
    checkOutput("rst_fault_pc", fault_pc, 32'd0);
    @(posedge clk);
    @(negedge clk);
    resetn      = 1'b1;
    m_pc        = RESET_PC;
    m_reqv      = 1'b1;
    m_wait      = 1'b0;
    m_instv     = 1'b0;
    m_stale     = 1'b0;
    m_fault     = 1'b0;
    m_fault_pc  = 32'h0;
    outstanding = 1'b0;
    expect_nop  = 1'b0;
    redir_armed = 1'b0;
    stall_cnt   = 0;
    hold_cnt    = knob_hold;
    sb.delete();
  endtask

  task automatic applyStimulus(input int n);
    for (int c = 0; c < n; c++) begin
      bit rsp, acc, redir, mis, fire;
      logic [31:0] tgt, rdata;
      int lat;

      checkOutput("req_valid", 32'(imem_req_valid), 32'(m_reqv));
      checkOutput("imem_addr", imem_addr, m_pc);
      checkOutput("inst_valid", 32'(inst_valid), 32'(m_instv));
      checkOutput("fetch_fault", 32'(fetch_fault), 32'(m_fault));
      checkOutput("fault_pc", fault_pc, m_fault_pc);
      if (m_instv) begin
        checkOutput("sb_occupied", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          checkOutput("inst", inst, sb[0].data);
          checkOutput("inst_pc", inst_pc, sb[0].addr);
          checkOutput("inst_pc_plus4", inst_pc_plus4, sb[0].addr + 32'd4);
        end
      end
      if (expect_nop) begin
        checkOutput("flush_inst", inst, NOP);
        expect_nop = 1'b0;
      end

      rsp   = outstanding && (out_cnt == 0);
      rdata = memData(out_addr);
      imem_rsp_valid = rsp;
      imem_rsp_data  = rsp ? rdata : 32'h0;

      if (m_reqv && stall_cnt > 0) begin
        imem_req_ready = 1'b0;
        stall_cnt--;
      end else begin
        imem_req_ready = knob_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end

      inst_ready = 1'b0;
      if (m_instv) begin
        if (hold_cnt > 0) hold_cnt--;
        else inst_ready = knob_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end

      redir = 1'b0;
      if (!m_fault) begin
        if (redir_armed) begin
          fire = (redir_when == 0) || (redir_when == 1 && m_wait) ||
                 (redir_when == 2 && m_instv) || (redir_when == 3 && m_reqv);
          if (fire) begin
            if (redir_skip > 0) redir_skip--;
            else begin
              redir       = 1'b1;
              redir_armed = 1'b0;
              redirect_pc = redir_target;
            end
          end
        end else if (knob_redir_pct > 0 && int'($urandom_range(0, 99)) < knob_redir_pct) begin
          redir       = 1'b1;
          redirect_pc = $urandom();
`ifdef FETCH_ALIGN_CHECK_EN
          redirect_pc[1:0] = 2'b00;
`endif
        end
      end
      redirect_valid = redir;
      tgt = redirect_pc & 32'hFFFF_FFFC;
`ifdef FETCH_ALIGN_CHECK_EN
      mis = redir && (redirect_pc[1:0] != 2'b00);
`else
      mis = 1'b0;
`endif

      acc = m_reqv && imem_req_ready;
      if (rsp) outstanding = 1'b0;
      else if (outstanding) out_cnt--;
      if (acc) begin
        lat         = (knob_lat > 0) ? knob_lat : int'($urandom_range(1, 3));
        outstanding = 1'b1;
        out_addr    = m_pc;
        out_cnt     = lat - 1;
      end

      if (m_fault) begin
      end else if (mis) begin
        m_fault    = 1'b1;
        m_fault_pc = redirect_pc;
        m_reqv     = 1'b0;
        m_wait     = 1'b0;
        m_instv    = 1'b0;
        sb.delete();
      end else if (m_reqv) begin
        if (redir) m_pc = tgt;
        if (acc) begin
          m_reqv  = 1'b0;
          m_wait  = 1'b1;
          m_stale = redir;
        end
      end else if (m_wait) begin
        if (rsp) begin
          m_wait = 1'b0;
          if (redir || m_stale) begin
            m_reqv  = 1'b1;
            m_stale = 1'b0;
            if (redir) m_pc = tgt;
          end else begin
            sb.push_back('{addr: out_addr, data: rdata});
            m_pc    = m_pc + 32'd4;
            m_instv = 1'b1;
          end
        end else if (redir) begin
          m_pc    = tgt;
          m_stale = 1'b1;
        end
      end else if (m_instv) begin
        if (redir) begin
          if (sb.size() != 0) void'(sb.pop_front());
          m_instv    = 1'b0;
          m_reqv     = 1'b1;
          m_pc       = tgt;
          expect_nop = 1'b1;
        end else if (inst_ready) begin
          if (sb.size() != 0) void'(sb.pop_front());
          m_instv  = 1'b0;
          m_reqv   = 1'b1;
          hold_cnt = knob_hold;
        end
      end

      @(negedge clk);
    end
  endtask

  initial begin
    resetn         = 1'b0;
    knob_rand      = 1'b0;
    knob_lat       = 1;
    knob_hold      = 0;
    knob_redir_pct = 0;
    out_addr       = 32'h0;
    out_cnt        = 0;
    @(negedge clk);
    doReset();

    // Back-to-back fetches from reset with an always-ready 1-cycle memory.
    applyStimulus(12);

    // Decode stalls for 5 cycles on each instruction.
    knob_hold = 5;
    hold_cnt  = 5;
    applyStimulus(20);
    knob_hold = 0;
    hold_cnt  = 0;

    // Redirect while a 3-cycle response is outstanding.
    knob_lat = 3;
    armRedirect(1, 0, 32'h0000_0100);
    applyStimulus(16);
    knob_lat = 1;

    // Redirect in OUT coinciding with inst_ready.
    armRedirect(2, 0, 32'h0000_0200);
    applyStimulus(10);

    // Memory stalls 4 cycles after reset; redirect lands on the second stall cycle.
    doReset();
    stall_cnt = 4;
    armRedirect(3, 1, 32'h0000_0040);
    applyStimulus(12);

    // PC wrap through 32'hFFFF_FFFC.
    armRedirect(0, 0, 32'hFFFF_FFF8);
    applyStimulus(14);

    // Misaligned redirect target.
    armRedirect(0, 0, 32'h0000_0102);
    applyStimulus(12);
`ifdef FETCH_ALIGN_CHECK_EN
    doReset();
`endif

    // Randomised traffic with random redirects, then a quiet drain.
    knob_rand      = 1'b1;
    knob_lat       = 0;
    knob_redir_pct = 8;
    applyStimulus(300);
    knob_rand      = 1'b0;
    knob_redir_pct = 0;
    knob_lat       = 1;
    applyStimulus(10);
    doReset();
    applyStimulus(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the multicycle RV32I core. Owns the program counter, issues one word read per instruction to instruction memory over a valid/ready request and valid-only response channel, and holds the fetched word in a registered instruction register. That register feeds the immediate extender and decoder directly. Control-flow changes from execute arrive on a redirect port that cancels any fetch in flight.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word aligned.
- `NOP_INSN`, default 32'h0000_0013: instruction register reset/flush value (`addi x0,x0,0`).

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `resetn`  in  1  reset; asynchronous assert, active-low.
- `imem_req_valid`  out  1  read request pending.
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_addr`  out  32  word address of the request; always equals `pc`.
- `imem_rsp_valid`  in  1  read data valid; exactly one response per accepted request, at least 1 cycle after acceptance.
- `imem_rsp_data`  in  32  read data.
- `redirect_valid`  in  1  one-cycle pulse: next fetch comes from `redirect_pc`.
- `redirect_pc`  in  32  redirect target.
- `inst_valid`  out  1  `inst` holds a fetched instruction.
- `inst_ready`  in  1  decode consumes `inst` this cycle.
- `inst`  out  32  instruction register.
- `inst_pc`  out  32  address of `inst`.
- `inst_pc_plus4`  out  32  `inst_pc + 4`, mod 2^32.
- `fetch_fault`  out  1  sticky misaligned-redirect fault (see Configuration).
- `fault_pc`  out  32  offending redirect target.

## Operation
- FSM states: REQ, WAIT, OUT, FAULT. Reset values:
  - state = REQ, `pc` = `RESET_PC`, `inst` = `NOP_INSN`, `inst_pc` = `RESET_PC`.
  - `inst_valid` = 0, `drop` = 0, `fetch_fault` = 0, `fault_pc` = 0.
- REQ: `imem_req_valid`=1.
  - `imem_req_ready` → WAIT.
  - Otherwise stay in REQ. `imem_addr` is held stable, except when a redirect arrives.
- WAIT: `imem_req_valid`=0.
  - `imem_rsp_valid` with `drop`=0: `inst`←`imem_rsp_data`, `inst_pc`←`pc`, `pc`←`pc+4`, → OUT.
  - `imem_rsp_valid` with `drop`=1: data discarded, `drop`←0, → REQ.
- OUT: `inst_valid`=1; `inst`, `inst_pc`, `inst_pc_plus4` are held stable.
  - `inst_ready` → REQ.
  - `inst` keeps its value after the handshake, so the immediate extender sees a stable word until the next capture.
- Redirect (`redirect_valid`=1) always wins over every simultaneous event. In every case `pc`←`redirect_pc`.
  - REQ, not accepted: stay in REQ. The request address changes to the new `pc` next cycle.
  - REQ, accepted same cycle: → WAIT with `drop`←1.
  - WAIT, no response this cycle: `drop`←1.
  - WAIT, response this cycle: response discarded, → REQ.
  - OUT: `inst_valid`←0, `inst`←`NOP_INSN`, → REQ. A simultaneous `inst_ready` is ignored; the instruction is not consumed.
- FAULT: all handshake outputs are 0; the only exit is `resetn`.
- `pc` wraps from 32'hFFFF_FFFC to 0 without a flag.

## Timing
- All outputs are registered, except `imem_addr` (a wire from `pc`) and `inst_pc_plus4` (combinational from `inst_pc`).
- Minimum fetch: request accepted in cycle t, response in t+1, `inst_valid` in t+2. A consume in t+2 puts the next request in t+3, giving 3 cycles per instruction.
- Redirect in cycle t: the request for `redirect_pc` is visible in t+1. If a response was outstanding, the new request instead follows the cycle the stale response returns.
- `resetn` low mid-fetch clears state immediately. Any response still in flight from before reset must be suppressed by the memory side; this block does not track it.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - Redirect with `redirect_pc[1:0]`≠0: `pc` is not updated and any outstanding response is dropped.
  - `fetch_fault`←1 and `fault_pc`←`redirect_pc`, both next cycle; → FAULT.
- Not defined:
  - `redirect_pc[1:0]` is forced to 00 when loaded.
  - `fetch_fault` and `fault_pc` are tied to 0; the FAULT state is unreachable.

## Test plan
- Reset, memory always ready, 1-cycle response: requests go to 0x0, 0x4, 0x8. Memory returns 32'h00500093 at 0x0. In cycle 2 `inst`=32'h00500093, `inst_pc`=0, `inst_pc_plus4`=4.
- `inst_ready` held low for 5 cycles in OUT: `inst` and `inst_pc` are stable, and no `imem_req_valid` is raised until `inst_ready` goes high.
- Redirect to 0x100 while in WAIT, response 3 cycles later: that response is dropped. The next request is to 0x100, and `inst_valid` never shows the stale word.
- Redirect to 0x200 in the same cycle as `inst_ready` in OUT: `inst_valid`=0 and `inst`=32'h00000013 next cycle. The next request is to 0x200.
- `imem_req_ready` low for 4 cycles: `imem_addr` is stable at 0x0; a redirect to 0x40 in cycle 2 changes it to 0x40 in cycle 3.
- With `FETCH_ALIGN_CHECK_EN`, redirect to 0x102: `fetch_fault`=1 and `fault_pc`=0x102 next cycle. `imem_req_valid` stays 0 until `resetn` is asserted.
